i2c_cfg_sequencer: RTL

I2C_CFG_SEQUENCER -- requirements
Module: i2c_cfg_sequencer

---
 rtl/i2c_seq_pkg.sv | 44 ++++
 rtl/ms_tick_gen.sv | 30 +++
 rtl/i2c_cfg_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C configuration sequencer: ROM entry layout,
// opcodes, error codes and FSM states.
package i2c_seq_pkg;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'd0,
        OP_VERIFY = 2'd1,
        OP_DELAY  = 2'd2,
        OP_END    = 2'd3
    } opcode_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_NACK     = 2'd1,
        ERR_MISMATCH = 2'd2,
        ERR_OVERRUN  = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_WAIT_RSP = 3'd4,
        ST_DELAY    = 3'd5,
        ST_DONE     = 3'd6,
        ST_FAIL     = 3'd7
    } state_e;

    // One 32-bit command word as stored in the configuration ROM.
    typedef struct packed {
        opcode_e    op;
        logic [6:0] dev;
        logic [6:0] rsvd;
        logic [7:0] regaddr;
        logic [7:0] data;
    } entry_t;

    // DELAY entries reuse the register and data bytes as a 16-bit ms count.
    function automatic logic [15:0] delay_ms(input entry_t e);
        return {e.regaddr, e.data};
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond tick generator. The count restarts whenever
// en is low, so the first tick arrives a full CLK_KHZ cycles after enable.
module ms_tick_gen #(
    parameter int CLK_KHZ = 74250
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_KHZ > 1) ? $clog2(CLK_KHZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_KHZ - 1);

    logic [CW-1:0] cnt;

    // Count clk cycles within the current millisecond, wrapping at LAST.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks a command ROM and turns each entry into byte-level I2C requests,
// millisecond delays or sequence termination, with per-entry retries.
module i2c_cfg_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int CLK_KHZ     = 74250,
    parameter int ROM_AW      = 8,
    parameter int MAX_RETRIES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [1:0]        err_code,
    output logic [ROM_AW-1:0] err_addr,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              txn_valid,
    input  logic              txn_ready,
    output logic [6:0]        txn_dev,
    output logic              txn_rnw,
    output logic [7:0]        txn_reg,
    output logic [7:0]        txn_wdata,
    input  logic              rsp_valid,
    input  logic              rsp_nack,
    input  logic [7:0]        rsp_rdata
);

    localparam logic [7:0]        RETRY_LIMIT = 8'(MAX_RETRIES);
    localparam logic [ROM_AW-1:0] LAST_ADDR   = '1;

    state_e            state;
    entry_t            cur;
    entry_t            fetched;
    err_code_e         err_q;
    logic [ROM_AW-1:0] addr_q;
    logic [ROM_AW-1:0] err_addr_q;
    logic [7:0]        retry_cnt;
    logic [15:0]       ms_cnt;
    logic              tick;
    logic              rsp_ok;
    logic              adv_req;
    logic              unused_rsvd;

    assign fetched     = entry_t'(rom_data);
    assign unused_rsvd = ^cur.rsvd;

    ms_tick_gen #(
        .CLK_KHZ(CLK_KHZ)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (state == ST_DELAY),
        .tick(tick)
    );

    assign rsp_ok = !rsp_nack && ((cur.op != OP_VERIFY) || (rsp_rdata == cur.data));

    // Decide whether the current entry completed successfully this cycle.
    always_comb begin
        adv_req = 1'b0;
        case (state)
            ST_DECODE:   adv_req = (fetched.op == OP_DELAY) && (delay_ms(fetched) == 16'd0);
            ST_WAIT_RSP: adv_req = rsp_valid && rsp_ok;
            ST_DELAY:    adv_req = tick && ((ms_cnt + 16'd1) == delay_ms(cur));
            default:     adv_req = 1'b0;
        endcase
    end

    // Main sequencer FSM; advancing past the last ROM slot is an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cur        <= '0;
            err_q      <= ERR_NONE;
            addr_q     <= '0;
            err_addr_q <= '0;
            retry_cnt  <= '0;
            ms_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start) begin
                        state      <= ST_FETCH;
                        addr_q     <= '0;
                        retry_cnt  <= '0;
                        err_q      <= ERR_NONE;
                        err_addr_q <= '0;
                    end
                end
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    cur    <= fetched;
                    ms_cnt <= '0;
                    case (fetched.op)
                        OP_WRITE, OP_VERIFY: state <= ST_ISSUE;
                        OP_DELAY: begin
                            if (!adv_req) state <= ST_DELAY;
                        end
                        default: state <= ST_DONE;
                    endcase
                end
                ST_ISSUE: begin
                    if (txn_ready) state <= ST_WAIT_RSP;
                end
                ST_WAIT_RSP: begin
                    if (rsp_valid && !rsp_ok) begin
                        if (retry_cnt < RETRY_LIMIT) begin
                            retry_cnt <= retry_cnt + 8'd1;
                            state     <= ST_ISSUE;
                        end else begin
                            state      <= ST_FAIL;
                            err_q      <= rsp_nack ? ERR_NACK : ERR_MISMATCH;
                            err_addr_q <= addr_q;
                        end
                    end
                end
                ST_DELAY: begin
                    if (tick && !adv_req) ms_cnt <= ms_cnt + 16'd1;
                end
                default: state <= ST_IDLE;
            endcase

            if (adv_req) begin
                retry_cnt <= '0;
                if (addr_q == LAST_ADDR) begin
                    state      <= ST_FAIL;
                    err_q      <= ERR_OVERRUN;
                    err_addr_q <= addr_q;
                end else begin
                    addr_q <= addr_q + ROM_AW'(1);
                    state  <= ST_FETCH;
                end
            end
        end
    end

    assign busy      = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_ISSUE) ||
                       (state == ST_WAIT_RSP) || (state == ST_DELAY);
    assign done      = (state == ST_DONE);
    assign fail      = (state == ST_FAIL);
    assign err_code  = err_q;
    assign err_addr  = err_addr_q;
    assign rom_addr  = addr_q;
    assign txn_valid = (state == ST_ISSUE);
    assign txn_dev   = cur.dev;
    assign txn_rnw   = (cur.op == OP_VERIFY);
    assign txn_reg   = cur.regaddr;
    assign txn_wdata = cur.data;

endmodule
